// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults, pair record and message text for the byte-pair collector
//
// Purpose: parameter defaults (W, PAD, CNT_W), the pair record handed to the
// concatenation stage, and the text printed on a handshake violation when
// BYTE_PAIR_ASSERT_MSG_EN is defined.
// Ports: none (package).

package bp_pkg;

  localparam int         W_DEF     = 8;
  localparam logic [7:0] PAD_DEF   = 8'h00;
  localparam int         CNT_W_DEF = 16;

  // Pair record at the default byte width.
  typedef struct packed {
    logic [W_DEF-1:0] x;
    logic [W_DEF-1:0] y;
    logic             last;
    logic             odd;
  } pair_t;

  localparam string ASSERT_MSG = "ASSERTION FAILED: byte_pair_collector handshake violation";

endpackage

// File: rtl/byte_pair_collector_if.sv
// rtl/byte_pair_collector_if.sv - byte-in / pair-out handshake bundle
//
// Purpose: groups the upstream byte stream and the downstream pair stream.
// Signals:
//   in_valid, in_ready, in_data[W], in_last         upstream byte handshake
//   out_valid, out_ready, out_x[W], out_y[W],
//   out_last, out_odd                               downstream pair handshake
// Modports:
//   slave  - the collector (consumes bytes, produces pairs)
//   master - the environment (produces bytes, consumes pairs)

interface byte_pair_collector_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;
  logic         out_last;
  logic         out_odd;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_x, out_y, out_last, out_odd
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_last, out_odd
  );

endinterface

// File: rtl/bp_handshake_checker.sv
// rtl/bp_handshake_checker.sv - sticky valid/ready protocol checker
//
// Purpose: flags a producer that drops valid, or changes data/last, while
// its previous offer was stalled (valid & !ready). The flag is sticky until
// reset. Reusable on any valid/ready/data/last stream.
// Optional feature: BYTE_PAIR_ASSERT_MSG_EN - in simulation (not under
// SYNTHESIS) prints bp_pkg::ASSERT_MSG to stderr and ends the run on the
// cycle the flag first rises.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_valid, i_ready  observed handshake
//   i_data[W], i_last observed payload
//   o_err             sticky violation flag

module bp_handshake_checker
  import bp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic         i_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  output logic         o_err
);

  logic         r_prev_valid;
  logic         r_prev_ready;
  logic [W-1:0] r_prev_data;
  logic         r_prev_last;
  logic         r_err;
  logic         w_violation;

  // Reset clears r_prev_valid, so the check is disarmed for the first cycle.
  assign w_violation = r_prev_valid & ~r_prev_ready &
                       (~i_valid | (i_data != r_prev_data) | (i_last != r_prev_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_valid <= 1'b0;
      r_prev_ready <= 1'b0;
      r_prev_data  <= '0;
      r_prev_last  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_prev_valid <= i_valid;
      r_prev_ready <= i_ready;
      r_prev_data  <= i_data;
      r_prev_last  <= i_last;
      if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;

`ifdef BYTE_PAIR_ASSERT_MSG_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && w_violation && !r_err) begin
      $error("%s", ASSERT_MSG);
      $finish;
    end
  end
`endif
`endif

endmodule

// File: rtl/byte_pair_collector.sv
// rtl/byte_pair_collector.sv - collects a byte stream into registered (x, y) pairs
//
// Purpose: first byte of a pair is x, second is y. A frame ending on an odd
// byte is closed with y = PAD and out_odd = 1. Output is a registered
// valid/ready stage with full throughput (fire and reload in one cycle).
// The upstream handshake is monitored by bp_handshake_checker.
// Optional feature: BYTE_PAIR_ASSERT_MSG_EN (see bp_handshake_checker).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   bus (slave)    in_valid/in_ready/in_data/in_last byte input,
//                  out_valid/out_ready/out_x/out_y/out_last/out_odd pair output
//   o_pair_count   pairs accepted downstream, wraps modulo 2^CNT_W
//   o_err          sticky upstream protocol violation

module byte_pair_collector
  import bp_pkg::*;
#(
  parameter int         W     = W_DEF,
  parameter logic [W-1:0] PAD = W'(PAD_DEF),
  parameter int         CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  byte_pair_collector_if.slave bus,
  output logic [CNT_W-1:0]     o_pair_count,
  output logic                 o_err
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,  // no byte held
    ST_HOLD      = 2'd1,  // x held, waiting for y
    ST_HOLD_LAST = 2'd2   // x held and it closed the frame: promote with PAD
  } hold_state_e;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         last;
    logic         odd;
  } pair_w_t;

  hold_state_e      r_state;
  hold_state_e      w_state_nxt;
  logic [W-1:0]     r_hi;
  pair_w_t          r_out;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_pair_count;

  logic w_out_free;
  logic w_fire;
  logic w_in_ready;
  logic w_capture;
  logic w_load_pair;
  logic w_load_odd;

  assign w_out_free = ~r_out_valid | bus.out_ready;
  assign w_fire     = r_out_valid & bus.out_ready;

  // in_ready is decided by the hold state and downstream room only, never by
  // the offered byte, so upstream may compute in_valid from in_ready freely.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_capture   = 1'b0;
    w_load_pair = 1'b0;
    w_load_odd  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = bus.in_last ? ST_HOLD_LAST : ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Only take y when the output register can take the pair.
        w_in_ready = w_out_free;
        if (bus.in_valid && w_out_free) begin
          w_load_pair = 1'b1;
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_HOLD_LAST: begin
        // Promotion of an odd frame end needs no input byte.
        if (w_out_free) begin
          w_load_odd  = 1'b1;
          w_state_nxt = ST_EMPTY;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi         <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_pair_count <= '0;
    end else begin
      if (w_capture) begin
        r_hi <= bus.in_data;
      end
      // A load in a firing cycle replaces the departing pair, keeping valid high.
      if (w_load_pair) begin
        r_out.x     <= r_hi;
        r_out.y     <= bus.in_data;
        r_out.last  <= bus.in_last;
        r_out.odd   <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (w_load_odd) begin
        r_out.x     <= r_hi;
        r_out.y     <= PAD;
        r_out.last  <= 1'b1;
        r_out.odd   <= 1'b1;
        r_out_valid <= 1'b1;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_fire) begin
        r_pair_count <= r_pair_count + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_x     = r_out.x;
  assign bus.out_y     = r_out.y;
  assign bus.out_last  = r_out.last;
  assign bus.out_odd   = r_out.odd;
  assign o_pair_count  = r_pair_count;

  bp_handshake_checker #(
    .W (W)
  ) u_in_checker (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.in_valid),
    .i_ready (w_in_ready),
    .i_data  (bus.in_data),
    .i_last  (bus.in_last),
    .o_err   (o_err)
  );

endmodule

// File: doc/byte_pair_collector.md
Name: byte_pair_collector

Overview:
- Upstream feeder for the byte-pair concatenation stage.
- Collects an 8-bit valid/ready byte stream into (x, y) pairs. The first byte of a pair becomes x (high half), the second becomes y (low half).
- Presents each pair on a registered valid/ready output, together with frame-end and odd-frame flags.
- Also checks the upstream handshake protocol and raises a sticky error.

Parameters:
- W, 8, byte width of in_data, out_x and out_y.
- PAD, 8'h00, value substituted for y when a frame ends on an odd byte.
- CNT_W, 16, width of the pair counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  collector can accept a byte.
- in_data  in  W  byte.
- in_last  in  1  byte is the last of its frame.
- out_valid  out  1  pair available.
- out_ready  in  1  downstream accepts the pair.
- out_x  out  W  first byte of the pair.
- out_y  out  W  second byte of the pair, or PAD.
- out_last  out  1  pair closes a frame.
- out_odd  out  1  y is padding.
- pair_count  out  CNT_W  number of pairs accepted downstream; wraps modulo 2^CNT_W.
- err  out  1  sticky upstream protocol violation.

Behaviour:
- Reset values: all outputs 0 except in_ready.
  - in_ready = 1 in the cycle after reset.
  - Held bytes are discarded; hi_valid = 0 and out_valid = 0.
- State:
  - Holding register hi, with flags hi_valid and hi_last.
  - Output register (out_x, out_y, out_last, out_odd, out_valid).
- Accept and fire conditions:
  - Input accept = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - out_free = !out_valid | out_ready.
- in_ready:
  - 1 when !hi_valid.
  - out_free when hi_valid & !hi_last.
  - 0 when hi_valid & hi_last.
  - in_ready never depends combinationally on in_valid, in_data or in_last.
- Accept with hi_valid = 0: hi <= in_data; hi_valid <= 1; hi_last <= in_last.
- Accept with hi_valid = 1 (second byte; out_free is guaranteed):
  - Output register <= {x = hi, y = in_data, last = in_last, odd = 0}.
  - out_valid <= 1; hi_valid <= 0.
- Odd frame end (hi_valid & hi_last & out_free):
  - Output register <= {x = hi, y = PAD, last = 1, odd = 1}.
  - out_valid <= 1; hi_valid <= 0.
  - This promotion needs no input.
- Fire with no new load: out_valid <= 0.
- Fire and load in the same cycle: the new pair replaces the old one and out_valid stays 1, giving full throughput.
- Latency: second byte accepted in cycle N -> out_valid in N+1. Odd-end promotion takes 1 cycle once out_free.
- Throughput: 1 pair every 2 input cycles sustained.
- Stability: while out_valid & !out_ready, all out_* fields are held unchanged.
- pair_count: +1 on each fire; wraps from 2^CNT_W-1 to 0.
- err:
  - Set when a cycle with in_valid & !in_ready is followed by a cycle where in_valid = 0, or in_data/in_last differ from the previous cycle.
  - Stays set until reset.
  - The check is disarmed in the first cycle after reset.
- Reset mid-pair or mid-stall: discards hi and the output register. No partial pair is emitted afterwards.

Optional Feature:
- Macro: BYTE_PAIR_ASSERT_MSG_EN.
- Defined: a simulation-only block (excluded under SYNTHESIS), on the cycle err first rises:
  - prints "ASSERTION FAILED: byte_pair_collector handshake violation" to stderr;
  - calls $finish.
- Undefined: no simulation side effects; the violation is reported only through the err port.

Decomposition:
- Shared package (bp_pkg):
  - W, PAD and CNT_W defaults.
  - typedef pair_t {x, y, last, odd}.
  - Assertion message string constant.
- Sub-module: bp_handshake_checker.
  - Registers the previous valid, ready, data and last.
  - Produces the sticky err.
  - Reusable on the downstream stage's input.
- Pairing and output logic stay in the top module.

Test Plan:
- Stream bytes 0x12, 0x34 (last) with out_ready = 1 -> one cycle after 0x34 is accepted, out_x = 0x12, out_y = 0x34, out_last = 1, out_odd = 0; pair_count = 1 after the fire.
- Frame 0xAA (last) alone -> out_x = 0xAA, out_y = PAD (0x00), out_odd = 1, out_last = 1; in_ready = 0 until promotion.
- Continuous bytes 0x01..0x08, out_ready = 1 -> 4 pairs {01,02}, {03,04}, {05,06}, {07,08} on consecutive fires spaced 2 cycles; pair_count = 4.
- Hold out_ready = 0 with pair {10,20} valid and feed 0x30, 0x40 -> out stays {10,20}; 0x30 accepted, then in_ready = 0. Release -> {10,20} then {30,40}, with no loss.
- Stall in_ready = 0 while in_valid = 1 with 0x55, then change in_data to 0x56 -> err = 1 next cycle and stays 1. With BYTE_PAIR_ASSERT_MSG_EN defined, the message prints and the simulation finishes.
- Assert reset while hi holds 0x77 and a pair is valid -> out_valid = 0, pair_count = 0, err = 0. The next byte is treated as x.
